// File: rtl/arm_pkg.sv
// Shared encodings for the ARM-style decode stage: ALU commands, opcodes, condition codes, modes and flags.
package arm_pkg;

    localparam logic [3:0] EXE_NOP = 4'b0000;
    localparam logic [3:0] EXE_MOV = 4'b0001;
    localparam logic [3:0] EXE_ADD = 4'b0010;
    localparam logic [3:0] EXE_ADC = 4'b0011;
    localparam logic [3:0] EXE_SUB = 4'b0100;
    localparam logic [3:0] EXE_SBC = 4'b0101;
    localparam logic [3:0] EXE_AND = 4'b0110;
    localparam logic [3:0] EXE_ORR = 4'b0111;
    localparam logic [3:0] EXE_EOR = 4'b1000;
    localparam logic [3:0] EXE_MVN = 4'b1001;

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_EOR = 4'b0001;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_ADD = 4'b0100;
    localparam logic [3:0] OP_ADC = 4'b0101;
    localparam logic [3:0] OP_SBC = 4'b0110;
    localparam logic [3:0] OP_TST = 4'b1000;
    localparam logic [3:0] OP_CMP = 4'b1010;
    localparam logic [3:0] OP_ORR = 4'b1100;
    localparam logic [3:0] OP_MOV = 4'b1101;
    localparam logic [3:0] OP_MVN = 4'b1111;

    typedef enum logic [3:0] {
        COND_EQ = 4'b0000, COND_NE = 4'b0001, COND_CS = 4'b0010, COND_CC = 4'b0011,
        COND_MI = 4'b0100, COND_PL = 4'b0101, COND_VS = 4'b0110, COND_VC = 4'b0111,
        COND_HI = 4'b1000, COND_LS = 4'b1001, COND_GE = 4'b1010, COND_LT = 4'b1011,
        COND_GT = 4'b1100, COND_LE = 4'b1101, COND_AL = 4'b1110, COND_NV = 4'b1111
    } cond_e;

    typedef enum logic [1:0] {
        MODE_ARITH  = 2'b00,
        MODE_MEM    = 2'b01,
        MODE_BRANCH = 2'b10,
        MODE_RSVD   = 2'b11
    } mode_e;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef struct packed {
        logic       mem_r_en;
        logic       mem_w_en;
        logic       wb_en;
        logic       b;
        logic       s;
        logic [3:0] exe_cmd;
    } ctrl_t;

    localparam ctrl_t CTRL_NONE = '0;

endpackage

// File: rtl/id_regfile_bypass.sv
// Architectural register file: two combinational read ports, one write port, optional write-through bypass.
module id_regfile_bypass #(
    parameter int DW     = 32,
    parameter int NREG   = 16,
    parameter int RAW    = 4,
    parameter int FWD_EN = 1
) (
    input  logic           clk_i,
    input  logic           rst_n_i,
    input  logic           we_i,
    input  logic [RAW-1:0] waddr_i,
    input  logic [DW-1:0]  wdata_i,
    input  logic [RAW-1:0] raddr_a_i,
    output logic [DW-1:0]  rdata_a_o,
    input  logic [RAW-1:0] raddr_b_i,
    output logic [DW-1:0]  rdata_b_o
);

    logic [DW-1:0] regs_q [NREG];

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
        end else if (we_i && (int'(waddr_i) < NREG)) begin
            regs_q[waddr_i] <= wdata_i;
        end
    end

    // Addresses beyond NREG (possible when NREG is not a power of two) read as zero.
    function automatic logic [DW-1:0] read_port(input logic [RAW-1:0] addr);
        if ((FWD_EN != 0) && we_i && (waddr_i == addr)) return wdata_i;
        if (int'(addr) < NREG) return regs_q[addr];
        return '0;
    endfunction

    assign rdata_a_o = read_port(raddr_a_i);
    assign rdata_b_o = read_port(raddr_b_i);

endmodule

// File: rtl/id_stage_pipe.sv
// Decode stage: condition check, control decode, operand read with bypass, and a flow-controlled ID/EX register.
module id_stage_pipe import arm_pkg::*; #(
    parameter int DW     = 32,
    parameter int NREG   = 16,
    parameter int RAW    = 4,
    parameter int FWD_EN = 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [31:0]    instruction,
    input  logic [31:0]    pc_in,
    input  logic [3:0]     status_reg,
    input  logic           hazard,
    input  logic           flush,
    input  logic           wb_wb_en,
    input  logic [RAW-1:0] wb_dest,
    input  logic [DW-1:0]  wb_value,
    output logic           out_valid,
    input  logic           out_ready,
    output logic           mem_r_en,
    output logic           mem_w_en,
    output logic           wb_en,
    output logic           b,
    output logic           s,
    output logic [3:0]     exe_cmd,
    output logic           imm,
    output logic           two_src,
    output logic [RAW-1:0] src1,
    output logic [RAW-1:0] src2,
    output logic [RAW-1:0] dest,
    output logic [11:0]    shift_operand,
    output logic [23:0]    signed_imm_24,
    output logic [DW-1:0]  val_rn,
    output logic [DW-1:0]  val_rm,
    output logic [31:0]    pc_out
);

    function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] nzcv);
        logic n, z, c, v;
        n = nzcv[FLAG_N];
        z = nzcv[FLAG_Z];
        c = nzcv[FLAG_C];
        v = nzcv[FLAG_V];
        case (cond_e'(cond))
            COND_EQ: return z;
            COND_NE: return ~z;
            COND_CS: return c;
            COND_CC: return ~c;
            COND_MI: return n;
            COND_PL: return ~n;
            COND_VS: return v;
            COND_VC: return ~v;
            COND_HI: return c & ~z;
            COND_LS: return ~c | z;
            COND_GE: return n == v;
            COND_LT: return n != v;
            COND_GT: return ~z & (n == v);
            COND_LE: return z | (n != v);
            COND_AL: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic ctrl_t decode(input logic [1:0] mode, input logic [3:0] op, input logic sbit);
        ctrl_t c;
        c = CTRL_NONE;
        case (mode_e'(mode))
            MODE_ARITH: begin
                c.s     = sbit;
                c.wb_en = 1'b1;
                case (op)
                    OP_MOV: c.exe_cmd = EXE_MOV;
                    OP_MVN: c.exe_cmd = EXE_MVN;
                    OP_ADD: c.exe_cmd = EXE_ADD;
                    OP_ADC: c.exe_cmd = EXE_ADC;
                    OP_SUB: c.exe_cmd = EXE_SUB;
                    OP_SBC: c.exe_cmd = EXE_SBC;
                    OP_AND: c.exe_cmd = EXE_AND;
                    OP_ORR: c.exe_cmd = EXE_ORR;
                    OP_EOR: c.exe_cmd = EXE_EOR;
                    OP_CMP: begin c.exe_cmd = EXE_SUB; c.wb_en = 1'b0; end
                    OP_TST: begin c.exe_cmd = EXE_AND; c.wb_en = 1'b0; end
                    default: c = CTRL_NONE;
                endcase
            end
            MODE_MEM: begin
                c.exe_cmd  = EXE_ADD;
                c.mem_r_en = sbit;
                c.wb_en    = sbit;
                c.mem_w_en = ~sbit;
            end
            MODE_BRANCH: begin
                c.b       = 1'b1;
                c.exe_cmd = EXE_NOP;
            end
            default: c = CTRL_NONE;
        endcase
        return c;
    endfunction

    function automatic logic [RAW-1:0] fit_addr(input logic [3:0] field);
        return RAW'(field);
    endfunction

    ctrl_t          dec_ctrl;
    ctrl_t          ctrl_d;
    logic           adv;
    logic [RAW-1:0] src1_d, src2_d, dest_d;
    logic           two_src_d;
    logic [DW-1:0]  rn_d, rm_d;

    assign dec_ctrl  = decode(instruction[27:26], instruction[24:21], instruction[20]);
    assign ctrl_d    = cond_pass(instruction[31:28], status_reg) ? dec_ctrl : CTRL_NONE;
    assign src1_d    = fit_addr(instruction[19:16]);
    assign dest_d    = fit_addr(instruction[15:12]);
    // Stores read Rd as the data operand; selection ignores the condition so operands stay meaningful.
    assign src2_d    = dec_ctrl.mem_w_en ? dest_d : fit_addr(instruction[3:0]);
    assign two_src_d = dec_ctrl.mem_w_en | ~instruction[25];

    assign adv      = ~out_valid | out_ready;
    assign in_ready = adv & ~hazard & ~flush;

    id_regfile_bypass #(.DW(DW), .NREG(NREG), .RAW(RAW), .FWD_EN(FWD_EN)) u_rf (
        .clk_i     (clk),
        .rst_n_i   (rst),
        .we_i      (wb_wb_en),
        .waddr_i   (wb_dest),
        .wdata_i   (wb_value),
        .raddr_a_i (src1_d),
        .rdata_a_o (rn_d),
        .raddr_b_i (src2_d),
        .rdata_b_o (rm_d)
    );

    ctrl_t          ctrl_q;
    logic           valid_q, imm_q, two_src_q;
    logic [RAW-1:0] src1_q, src2_q, dest_q;
    logic [11:0]    shift_q;
    logic [23:0]    simm_q;
    logic [DW-1:0]  rn_q, rm_q;
    logic [31:0]    pc_q;

    // ID/EX register: flush beats everything, then advance captures or bubbles, otherwise hold.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q   <= 1'b0;
            ctrl_q    <= CTRL_NONE;
            imm_q     <= 1'b0;
            two_src_q <= 1'b0;
            src1_q    <= '0;
            src2_q    <= '0;
            dest_q    <= '0;
            shift_q   <= '0;
            simm_q    <= '0;
            rn_q      <= '0;
            rm_q      <= '0;
            pc_q      <= '0;
        end else if (flush) begin
            valid_q <= 1'b0;
            ctrl_q  <= CTRL_NONE;
        end else if (adv) begin
            if (in_valid && !hazard) begin
                valid_q   <= 1'b1;
                ctrl_q    <= ctrl_d;
                imm_q     <= instruction[25];
                two_src_q <= two_src_d;
                src1_q    <= src1_d;
                src2_q    <= src2_d;
                dest_q    <= dest_d;
                shift_q   <= instruction[11:0];
                simm_q    <= instruction[23:0];
                rn_q      <= rn_d;
                rm_q      <= rm_d;
                pc_q      <= pc_in;
            end else begin
                valid_q <= 1'b0;
                ctrl_q  <= CTRL_NONE;
            end
        end
    end

    assign out_valid     = valid_q;
    assign mem_r_en      = ctrl_q.mem_r_en;
    assign mem_w_en      = ctrl_q.mem_w_en;
    assign wb_en         = ctrl_q.wb_en;
    assign b             = ctrl_q.b;
    assign s             = ctrl_q.s;
    assign exe_cmd       = ctrl_q.exe_cmd;
    assign imm           = imm_q;
    assign two_src       = two_src_q;
    assign src1          = src1_q;
    assign src2          = src2_q;
    assign dest          = dest_q;
    assign shift_operand = shift_q;
    assign signed_imm_24 = simm_q;
    assign val_rn        = rn_q;
    assign val_rm        = rm_q;
    assign pc_out        = pc_q;

endmodule

// File: tb/tb_id_stage_pipe.sv
// Directed bench for id_stage_pipe with an expected-result queue; a second instance checks the no-bypass build.
module tb_id_stage_pipe;

    localparam int DW   = 32;
    localparam int NREG = 16;
    localparam int RAW  = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst, in_valid, hazard, flush, wb_wb_en, out_ready;
    logic [31:0]    instruction, pc_in;
    logic [3:0]     status_reg;
    logic [RAW-1:0] wb_dest;
    logic [DW-1:0]  wb_value;

    logic           in_ready, out_valid, mem_r_en, mem_w_en, wb_en, b, s, imm, two_src;
    logic [3:0]     exe_cmd;
    logic [RAW-1:0] src1, src2, dest;
    logic [11:0]    shift_operand;
    logic [23:0]    signed_imm_24;
    logic [DW-1:0]  val_rn, val_rm;
    logic [31:0]    pc_out;

    logic           nf_in_ready, nf_out_valid, nf_mem_r_en, nf_mem_w_en, nf_wb_en, nf_b, nf_s, nf_imm, nf_two_src;
    logic [3:0]     nf_exe_cmd;
    logic [RAW-1:0] nf_src1, nf_src2, nf_dest;
    logic [11:0]    nf_shift_operand;
    logic [23:0]    nf_signed_imm_24;
    logic [DW-1:0]  nf_val_rn, nf_val_rm;
    logic [31:0]    nf_pc_out;

    id_stage_pipe #(.DW(DW), .NREG(NREG), .RAW(RAW), .FWD_EN(1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .instruction(instruction), .pc_in(pc_in), .status_reg(status_reg),
        .hazard(hazard), .flush(flush), .wb_wb_en(wb_wb_en), .wb_dest(wb_dest),
        .wb_value(wb_value), .out_valid(out_valid), .out_ready(out_ready),
        .mem_r_en(mem_r_en), .mem_w_en(mem_w_en), .wb_en(wb_en), .b(b), .s(s),
        .exe_cmd(exe_cmd), .imm(imm), .two_src(two_src), .src1(src1), .src2(src2),
        .dest(dest), .shift_operand(shift_operand), .signed_imm_24(signed_imm_24),
        .val_rn(val_rn), .val_rm(val_rm), .pc_out(pc_out)
    );

    id_stage_pipe #(.DW(DW), .NREG(NREG), .RAW(RAW), .FWD_EN(0)) dut_nf (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(nf_in_ready),
        .instruction(instruction), .pc_in(pc_in), .status_reg(status_reg),
        .hazard(hazard), .flush(flush), .wb_wb_en(wb_wb_en), .wb_dest(wb_dest),
        .wb_value(wb_value), .out_valid(nf_out_valid), .out_ready(out_ready),
        .mem_r_en(nf_mem_r_en), .mem_w_en(nf_mem_w_en), .wb_en(nf_wb_en), .b(nf_b), .s(nf_s),
        .exe_cmd(nf_exe_cmd), .imm(nf_imm), .two_src(nf_two_src), .src1(nf_src1), .src2(nf_src2),
        .dest(nf_dest), .shift_operand(nf_shift_operand), .signed_imm_24(nf_signed_imm_24),
        .val_rn(nf_val_rn), .val_rm(nf_val_rm), .pc_out(nf_pc_out)
    );

    typedef struct packed {
        logic           ov;
        logic [8:0]     ctl;
        logic           imm;
        logic           two;
        logic [RAW-1:0] s1;
        logic [RAW-1:0] s2;
        logic [RAW-1:0] d;
        logic [11:0]    sh;
        logic [23:0]    si;
        logic [DW-1:0]  vn;
        logic [DW-1:0]  vm;
        logic [31:0]    pc;
    } exp_t;

    // ctl packing: {mem_r_en, mem_w_en, wb_en, b, s, exe_cmd}
    localparam logic [8:0] C_NONE = 9'b0;
    localparam logic [8:0] C_ADD  = {5'b00100, 4'b0010};
    localparam logic [8:0] C_MOV  = {5'b00100, 4'b0001};
    localparam logic [8:0] C_LDR  = {5'b10100, 4'b0010};
    localparam logic [8:0] C_STR  = {5'b01000, 4'b0010};
    localparam logic [8:0] C_CMP  = {5'b00001, 4'b0100};
    localparam logic [8:0] C_B    = {5'b00010, 4'b0000};

    exp_t exp_q[$];
    exp_t last;
    int   n_chk = 0;
    int   n_err = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] ins, input logic [31:0] pc);
        in_valid    = 1'b1;
        instruction = ins;
        pc_in       = pc;
    endtask

    task automatic push(input logic [8:0] ctl, input logic im, input logic two,
                        input logic [RAW-1:0] s1, input logic [RAW-1:0] s2, input logic [RAW-1:0] d,
                        input logic [31:0] ins, input logic [DW-1:0] vn, input logic [DW-1:0] vm,
                        input logic [31:0] pc);
        exp_t e;
        logic [31:0] w;
        w    = ins;
        e.ov = 1'b1; e.ctl = ctl; e.imm = im; e.two = two;
        e.s1 = s1; e.s2 = s2; e.d = d;
        e.sh = w[11:0]; e.si = w[23:0];
        e.vn = vn; e.vm = vm; e.pc = pc;
        exp_q.push_back(e);
    endtask

    task automatic cmp(input string tag, input exp_t e);
        chk({tag, ".valid"}, out_valid, e.ov);
        chk({tag, ".ctl"}, {mem_r_en, mem_w_en, wb_en, b, s, exe_cmd}, e.ctl);
        chk({tag, ".imm"}, imm, e.imm);
        chk({tag, ".two_src"}, two_src, e.two);
        chk({tag, ".src1"}, src1, e.s1);
        chk({tag, ".src2"}, src2, e.s2);
        chk({tag, ".dest"}, dest, e.d);
        chk({tag, ".shift"}, shift_operand, e.sh);
        chk({tag, ".simm"}, signed_imm_24, e.si);
        chk({tag, ".val_rn"}, val_rn, e.vn);
        chk({tag, ".val_rm"}, val_rm, e.vm);
        chk({tag, ".pc"}, pc_out, e.pc);
    endtask

    task automatic pop_check(input string tag);
        chk({tag, ".sb_nonempty"}, exp_q.size() != 0, 1'b1);
        if (exp_q.size() != 0) begin
            last = exp_q.pop_front();
            cmp(tag, last);
        end
    endtask

    initial begin
        rst = 1'b0; in_valid = 1'b0; hazard = 1'b0; flush = 1'b0; out_ready = 1'b1;
        wb_wb_en = 1'b0; wb_dest = '0; wb_value = '0;
        instruction = 32'hE082_1003; pc_in = 32'h0; status_reg = 4'b0000;
        tick(); tick();
        chk("reset.valid", out_valid, 1'b0);
        chk("reset.ctl", {mem_r_en, mem_w_en, wb_en, b, s, exe_cmd}, C_NONE);
        chk("reset.val_rn", val_rn, 32'h0);
        chk("reset.pc", pc_out, 32'h0);
        rst = 1'b1;

        // Preload r2=5, r3=7 through the write-back port.
        wb_wb_en = 1'b1; wb_dest = 4'd2; wb_value = 32'd5;
        tick();
        wb_dest = 4'd3; wb_value = 32'd7;
        tick();
        wb_wb_en = 1'b0;
        chk("idle.valid", out_valid, 1'b0);

        // ADD r1,r2,r3
        drive(32'hE082_1003, 32'h100);
        #1 chk("add.in_ready", in_ready, 1'b1);
        push(C_ADD, 1'b0, 1'b1, 4'd2, 4'd3, 4'd1, 32'hE082_1003, 32'd5, 32'd7, 32'h100);
        tick();
        pop_check("add");

        // Same-cycle write-back of r2 while it is read.
        drive(32'hE082_1003, 32'h104);
        wb_wb_en = 1'b1; wb_dest = 4'd2; wb_value = 32'hAA;
        push(C_ADD, 1'b0, 1'b1, 4'd2, 4'd3, 4'd1, 32'hE082_1003, 32'hAA, 32'd7, 32'h104);
        tick();
        wb_wb_en = 1'b0;
        pop_check("fwd");
        chk("nofwd.val_rn", nf_val_rn, 32'd5);

        // ADDEQ with Z=0 fails, then with Z=1 passes.
        drive(32'h0082_1003, 32'h110);
        status_reg = 4'b0000;
        push(C_NONE, 1'b0, 1'b1, 4'd2, 4'd3, 4'd1, 32'h0082_1003, 32'hAA, 32'd7, 32'h110);
        tick();
        pop_check("addeq_fail");
        drive(32'h0082_1003, 32'h114);
        status_reg = 4'b0100;
        push(C_ADD, 1'b0, 1'b1, 4'd2, 4'd3, 4'd1, 32'h0082_1003, 32'hAA, 32'd7, 32'h114);
        tick();
        pop_check("addeq_pass");
        status_reg = 4'b0000;

        // Stall from EXE for three cycles, with a write-back landing during the stall.
        drive(32'hE3A0_5012, 32'h118);
        out_ready = 1'b0;
        wb_wb_en = 1'b1; wb_dest = 4'd3; wb_value = 32'h33;
        #1 chk("stall.in_ready", in_ready, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            wb_wb_en = 1'b0;
            cmp($sformatf("stall%0d", i), last);
        end
        // r3 was rewritten during the stall; restore it so later operand values stay simple.
        wb_wb_en = 1'b1; wb_dest = 4'd3; wb_value = 32'd7;
        out_ready = 1'b1;
        #1 chk("release.in_ready", in_ready, 1'b1);
        push(C_MOV, 1'b1, 1'b0, 4'd0, 4'd2, 4'd5, 32'hE3A0_5012, 32'h0, 32'hAA, 32'h118);
        tick();
        wb_wb_en = 1'b0;
        pop_check("mov");

        // Decode patterns: LDR, STR, CMP, B, unknown opcode (RSB).
        drive(32'hE592_1004, 32'h11C);
        push(C_LDR, 1'b0, 1'b1, 4'd2, 4'd4, 4'd1, 32'hE592_1004, 32'hAA, 32'h0, 32'h11C);
        tick(); pop_check("ldr");
        drive(32'hE582_1004, 32'h120);
        push(C_STR, 1'b0, 1'b1, 4'd2, 4'd1, 4'd1, 32'hE582_1004, 32'hAA, 32'h0, 32'h120);
        tick(); pop_check("str");
        drive(32'hE152_0003, 32'h124);
        push(C_CMP, 1'b0, 1'b1, 4'd2, 4'd3, 4'd0, 32'hE152_0003, 32'hAA, 32'd7, 32'h124);
        tick(); pop_check("cmp");
        drive(32'hEA00_0010, 32'h128);
        push(C_B, 1'b1, 1'b0, 4'd0, 4'd0, 4'd0, 32'hEA00_0010, 32'h0, 32'h0, 32'h128);
        tick(); pop_check("branch");
        drive(32'hE062_1003, 32'h12C);
        push(C_NONE, 1'b0, 1'b1, 4'd2, 4'd3, 4'd1, 32'hE062_1003, 32'hAA, 32'd7, 32'h12C);
        tick(); pop_check("unknown");

        // Hazard for one cycle inserts a bubble, then the same instruction is taken.
        drive(32'hE082_1003, 32'h200);
        hazard = 1'b1;
        #1 chk("hazard.in_ready", in_ready, 1'b0);
        tick();
        chk("hazard.valid", out_valid, 1'b0);
        chk("hazard.ctl", {mem_r_en, mem_w_en, wb_en, b, s, exe_cmd}, C_NONE);
        hazard = 1'b0;
        #1 chk("hazard_rel.in_ready", in_ready, 1'b1);
        push(C_ADD, 1'b0, 1'b1, 4'd2, 4'd3, 4'd1, 32'hE082_1003, 32'hAA, 32'd7, 32'h200);
        tick(); pop_check("after_hazard");

        // Flush wins over hazard and over an EXE stall.
        drive(32'hE3A0_5012, 32'h204);
        flush = 1'b1; hazard = 1'b1; out_ready = 1'b0;
        #1 chk("flush.in_ready", in_ready, 1'b0);
        tick();
        chk("flush.valid", out_valid, 1'b0);
        chk("flush.ctl", {mem_r_en, mem_w_en, wb_en, b, s, exe_cmd}, C_NONE);
        flush = 1'b0; hazard = 1'b0; out_ready = 1'b1;

        // Asynchronous reset in the middle of a stall.
        drive(32'hE082_1003, 32'h2F0);
        push(C_ADD, 1'b0, 1'b1, 4'd2, 4'd3, 4'd1, 32'hE082_1003, 32'hAA, 32'd7, 32'h2F0);
        tick(); pop_check("pre_reset");
        out_ready = 1'b0;
        tick();
        chk("stall_pre_reset.valid", out_valid, 1'b1);
        #2 rst = 1'b0;
        #1;
        chk("midrst.valid", out_valid, 1'b0);
        chk("midrst.pc", pc_out, 32'h0);
        chk("midrst.val_rn", val_rn, 32'h0);
        chk("midrst.dest", dest, 4'd0);
        tick();
        rst = 1'b1; out_ready = 1'b1;
        drive(32'hE082_1003, 32'h300);
        push(C_ADD, 1'b0, 1'b1, 4'd2, 4'd3, 4'd1, 32'hE082_1003, 32'h0, 32'h0, 32'h300);
        tick(); pop_check("post_reset");
        in_valid = 1'b0;
        tick();
        chk("end.valid", out_valid, 1'b0);
        chk("end.sb_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
